// File: rtl/display_pixel_fetch.sv
// Pixel source for the display timing generator: turns (xpos, ypos) requests into RGB565
// pixels one clock later, popping a FWFT frame FIFO and drawing an optional box overlay.
module display_pixel_fetch #(
  parameter int          H_DISP    = 640,
  parameter int          V_DISP    = 480,
  parameter int          IMG_X     = 1,
  parameter int          IMG_Y     = 1,
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          BOX_T     = 2,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter logic [15:0] UF_COLOR  = 16'hF800,
  parameter logic [15:0] BOX_COLOR = 16'h07E0
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        frame_start,
  input  logic        box_en,
  input  logic [10:0] box_x0,
  input  logic [10:0] box_x1,
  input  logic [10:0] box_y0,
  input  logic [10:0] box_y1,
  output logic        uf_flag,
  output logic [15:0] uf_count
);

  localparam logic [11:0] X_LO  = 12'(IMG_X);
  localparam logic [11:0] X_HI  = 12'(IMG_X + IMG_W - 1);
  localparam logic [11:0] Y_LO  = 12'(IMG_Y);
  localparam logic [11:0] Y_HI  = 12'(IMG_Y + IMG_H - 1);
  localparam logic [11:0] H_MAX = 12'(H_DISP);
  localparam logic [11:0] V_MAX = 12'(V_DISP);
  localparam logic [11:0] THICK = 12'(BOX_T);

  typedef enum logic {WAIT_SYNC, RUN} state_e;

  state_e      state_q;
  logic [15:0] pixel_q, pixel_d;
  logic        frame_start_q;
  logic        uf_flag_q;
  logic [15:0] uf_count_q, uf_count_d;
  logic        sh_en_q;
  logic [10:0] sh_x0_q, sh_x1_q, sh_y0_q, sh_y1_q;

  logic        req, in_img, sof, active, underflow;
  logic        box_on_sel, inside_box, near_edge, on_box;
  logic [11:0] x, y, bx0, bx1, by0, by1;

  assign x      = {1'b0, pixel_xpos};
  assign y      = {1'b0, pixel_ypos};
  assign req    = (pixel_xpos != 11'd0);
  assign in_img = req && (x >= X_LO) && (x <= X_HI) && (x <= H_MAX)
                      && (y >= Y_LO) && (y <= Y_HI) && (y <= V_MAX);
  assign sof    = req && (pixel_xpos == 11'd1) && (pixel_ypos == 11'd1);

  // The sof pixel already belongs to the new frame, so it is served as if running.
  assign active    = (state_q == RUN) || sof;
  assign underflow = active && in_img && fifo_empty;
  assign fifo_rd_en = !sys_rst && active && in_img && !fifo_empty;

  // The shadow box is only loaded at the sof edge, so the sof pixel itself uses the live inputs.
  assign box_on_sel = sof ? box_en : sh_en_q;
  assign bx0 = {1'b0, sof ? box_x0 : sh_x0_q};
  assign bx1 = {1'b0, sof ? box_x1 : sh_x1_q};
  assign by0 = {1'b0, sof ? box_y0 : sh_y0_q};
  assign by1 = {1'b0, sof ? box_y1 : sh_y1_q};

  // An inverted rectangle (x0>x1 or y0>y1) makes inside_box false, so nothing is drawn.
  assign inside_box = (x >= bx0) && (x <= bx1) && (y >= by0) && (y <= by1);
  assign near_edge  = ((x - bx0) < THICK) || ((bx1 - x) < THICK)
                   || ((y - by0) < THICK) || ((by1 - y) < THICK);
  assign on_box     = box_on_sel && inside_box && near_edge;

  // NOTE: every always_comb output is given a default first so no latch can be inferred.
  always_comb begin
    pixel_d    = BG_COLOR;
    uf_count_d = uf_count_q;
    if (req && active) begin
      if (on_box)         pixel_d = BOX_COLOR;
      else if (underflow) pixel_d = UF_COLOR;
      else if (in_img)    pixel_d = fifo_dout;
    end
    if (underflow && (uf_count_q != 16'hFFFF)) uf_count_d = uf_count_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q       <= WAIT_SYNC;
      pixel_q       <= BG_COLOR;
      frame_start_q <= 1'b0;
      uf_flag_q     <= 1'b0;
      uf_count_q    <= 16'd0;
      sh_en_q       <= 1'b0;
      sh_x0_q       <= 11'd0;
      sh_x1_q       <= 11'd0;
      sh_y0_q       <= 11'd0;
      sh_y1_q       <= 11'd0;
    end else begin
      case (state_q)
        WAIT_SYNC: if (sof) state_q <= RUN;
        RUN:       state_q <= RUN;
        default:   state_q <= WAIT_SYNC;
      endcase
      pixel_q       <= pixel_d;
      frame_start_q <= sof;
      uf_count_q    <= uf_count_d;
      if (underflow) uf_flag_q <= 1'b1;
      if (sof) begin
        sh_en_q <= box_en;
        sh_x0_q <= box_x0;
        sh_x1_q <= box_x1;
        sh_y0_q <= box_y0;
        sh_y1_q <= box_y1;
      end
    end
  end

  assign pixel_data  = pixel_q;
  assign frame_start = frame_start_q;
  assign uf_flag     = uf_flag_q;
  assign uf_count    = uf_count_q;

endmodule

// File: tb/tb_display_pixel_fetch.sv
// Self-checking bench for display_pixel_fetch on a scaled-down 40x30 display with a 32x24 image,
// using a queue-based FIFO and a frame-level behavioural model of the pixel rules.
module tb_display_pixel_fetch;

  localparam int H  = 40;
  localparam int V  = 30;
  localparam int IX = 1;
  localparam int IY = 1;
  localparam int IW = 32;
  localparam int IH = 24;
  localparam int T  = 2;
  localparam logic [15:0] BG  = 16'h0000;
  localparam logic [15:0] UFC = 16'hF800;
  localparam logic [15:0] BOX = 16'h07E0;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic [15:0] pixel_data, fifo_dout;
  logic        fifo_empty, fifo_rd_en, frame_start;
  logic        box_en;
  logic [10:0] box_x0, box_x1, box_y0, box_y1;
  logic        uf_flag;
  logic [15:0] uf_count;

  always #5 clk = ~clk;

  display_pixel_fetch #(
    .H_DISP(H), .V_DISP(V), .IMG_X(IX), .IMG_Y(IY), .IMG_W(IW), .IMG_H(IH), .BOX_T(T),
    .BG_COLOR(BG), .UF_COLOR(UFC), .BOX_COLOR(BOX)
  ) dut (
    .pixel_clk(clk), .sys_rst(sys_rst),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .pixel_data(pixel_data),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .frame_start(frame_start),
    .box_en(box_en), .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
    .uf_flag(uf_flag), .uf_count(uf_count)
  );

  int errors = 0;
  int checks = 0;

  // FIFO contents and stimulus knobs
  logic [15:0] q[$];
  logic [15:0] seq_word = 16'd0;
  bit rand_data = 0, rand_starve = 0;
  int st_y = 0, st_x0 = 0, st_x1 = -1;
  int chg_line = 0, chg_val = 0;
  int rst_line = 0, rst_x = 0;
  int b_en = 0, b_x0 = 0, b_x1 = 0, b_y0 = 0, b_y1 = 0;

  // Reference model state
  bit          m_run = 0, m_sh_en = 0, m_fs = 0, m_uf = 0;
  int          m_sx0 = 0, m_sx1 = 0, m_sy0 = 0, m_sy1 = 0;
  logic [15:0] m_pix = BG;
  int          m_cnt = 0;
  int          dut_pops = 0, fs_seen = 0, frame_ufs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int x, input int y);
    bit req, inimg, sof, act, emp, uf, rd, ob, en;
    int x0, x1, y0, y1;
    logic [15:0] head, nxt;
    while (q.size() < 4) begin
      if (rand_data) q.push_back(16'($urandom));
      else begin
        q.push_back(seq_word);
        seq_word = seq_word + 16'd1;
      end
    end
    emp  = (rand_starve && $urandom_range(7) == 0) || (y == st_y && x >= st_x0 && x <= st_x1);
    head = q[0];
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    fifo_dout  = head;
    fifo_empty = emp;
    box_en = b_en[0];
    box_x0 = 11'(b_x0); box_x1 = 11'(b_x1);
    box_y0 = 11'(b_y0); box_y1 = 11'(b_y1);

    req   = (x != 0);
    inimg = req && x >= IX && x <= IX + IW - 1 && y >= IY && y <= IY + IH - 1;
    sof   = req && x == 1 && y == 1;
    act   = m_run || sof;
    if (sof) begin
      en = b_en[0]; x0 = b_x0; x1 = b_x1; y0 = b_y0; y1 = b_y1;
    end else begin
      en = m_sh_en; x0 = m_sx0; x1 = m_sx1; y0 = m_sy0; y1 = m_sy1;
    end
    rd = !sys_rst && act && inimg && !emp;
    uf = act && inimg && emp;
    // A pixel is on the border when inside the rectangle and closer than T to its nearest edge.
    ob = en && x >= x0 && x <= x1 && y >= y0 && y <= y1 &&
         (x - x0 < T || x1 - x < T || y - y0 < T || y1 - y < T);
    if (!req || !act) nxt = BG;
    else if (ob)      nxt = BOX;
    else if (uf)      nxt = UFC;
    else if (inimg)   nxt = head;
    else              nxt = BG;

    #4;
    check("rd_en", {31'd0, fifo_rd_en}, {31'd0, rd});
    if (fifo_rd_en) dut_pops++;
    @(posedge clk);
    if (sys_rst) begin
      m_run = 0; m_sh_en = 0; m_pix = BG; m_fs = 0; m_uf = 0; m_cnt = 0;
    end else begin
      if (sof) begin
        m_run = 1; m_sh_en = en; m_sx0 = x0; m_sx1 = x1; m_sy0 = y0; m_sy1 = y1;
      end
      m_pix = nxt;
      m_fs  = sof;
      if (uf) begin
        m_uf = 1;
        frame_ufs++;
        if (m_cnt != 65535) m_cnt++;
      end
      if (rd) void'(q.pop_front());
    end
    #1;
    check("pixel_data", {16'd0, pixel_data}, {16'd0, m_pix});
    check("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    check("uf_flag", {31'd0, uf_flag}, {31'd0, m_uf});
    check("uf_count", {16'd0, uf_count}, 32'(m_cnt));
    if (frame_start) fs_seen++;
  endtask

  task automatic scan(input int y_start);
    dut_pops = 0; fs_seen = 0; frame_ufs = 0;
    for (int y = y_start; y <= V; y++) begin
      for (int x = 1; x <= H; x++) begin
        if (y == chg_line && x == 1) b_x0 = chg_val;
        sys_rst = (y == rst_line && x == rst_x);
        cycle(x, y);
      end
      sys_rst = 1'b0;
      cycle(0, y);
      cycle(0, y);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    cycle(0, 0);
    cycle(7, 3);
    sys_rst = 1'b0;
    check("reset_pixel", {16'd0, pixel_data}, {16'd0, BG});
    check("reset_uf_count", {16'd0, uf_count}, 32'd0);

    // Requests begin mid-frame: background only, nothing popped until sof.
    scan(10);
    check("wait_sync_pops", 32'(dut_pops), 32'd0);

    // Full frame of sequential data.
    scan(1);
    check("frame1_pops", 32'(dut_pops), 32'(IW * IH));
    check("frame1_fs", 32'(fs_seen), 32'd1);
    check("frame1_ufcnt", {16'd0, uf_count}, 32'd0);

    // Starve x=10..14 of line 1.
    st_y = 1; st_x0 = 10; st_x1 = 14;
    scan(1);
    st_y = 0; st_x1 = -1;
    check("starve_ufcnt", {16'd0, uf_count}, 32'd5);
    check("starve_flag", {31'd0, uf_flag}, 32'd1);
    check("starve_pops", 32'(dut_pops), 32'(IW * IH - 5));

    // Box 10..20 x 5..12.
    b_en = 1; b_x0 = 10; b_x1 = 20; b_y0 = 5; b_y1 = 12;
    scan(1);
    check("box_pops", 32'(dut_pops), 32'(IW * IH));

    // Mid-frame box change has no effect until the next frame.
    chg_line = 8; chg_val = 14;
    scan(1);
    chg_line = 0;
    check("boxchg_pops", 32'(dut_pops), 32'(IW * IH));

    // Inverted box draws nothing.
    b_x0 = 25;
    scan(1);
    check("inv_box_pops", 32'(dut_pops), 32'(IW * IH));

    // Reset in the middle of a frame, then a clean frame.
    rst_line = 5; rst_x = 20;
    scan(1);
    rst_line = 0;
    check("post_rst_flag", {31'd0, uf_flag}, 32'd0);
    scan(1);
    check("after_rst_pops", 32'(dut_pops), 32'(IW * IH));
    check("after_rst_fs", 32'(fs_seen), 32'd1);

    // Random data, random starvation, random (possibly inverted or off-image) boxes.
    rand_data = 1; rand_starve = 1;
    for (int f = 0; f < 3; f++) begin
      b_en = int'($urandom_range(1));
      b_x0 = int'($urandom_range(1, H)); b_x1 = int'($urandom_range(1, H));
      b_y0 = int'($urandom_range(1, V)); b_y1 = int'($urandom_range(1, V));
      scan(1);
      check("rand_pops", 32'(dut_pops), 32'(IW * IH - frame_ufs));
      check("rand_fs", 32'(fs_seen), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
